uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the full-duplex UART receiver. It captures each completed character: 8-bit data, ninth bit, parity-error and framing-error flags. Capture is triggered on the rising edge of the receiver's completion flag. Characters are stored in a first-word-fall-through FIFO and presented to the host through a valid/ready read port, with occupancy, threshold and sticky overrun status.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2
ADDR_W, 3, log2(DEPTH); pointer width
AF_LEVEL, 6, almost_full asserts when level >= AF_LEVEL; range 1..DEPTH

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx_data  input  8  received character from UART receiver
rx_ninth  input  1  received ninth bit
rx_perr  input  1  parity error for current character
rx_ferr  input  1  framing error for current character
rx_done  input  1  receiver completion flag (level; may stay high several cycles)
flush  input  1  synchronous FIFO clear
clr_overrun  input  1  clears sticky overrun flag
rd_ready  input  1  host accepts head entry
rd_valid  output  1  head entry available
rd_data  output  8  head data
rd_ninth  output  1  head ninth bit
rd_perr  output  1  head parity-error flag
rd_ferr  output  1  head framing-error flag
level  output  ADDR_W+1  entries currently stored, 0..DEPTH
empty  output  1  level == 0
full  output  1  level == DEPTH
almost_full  output  1  level >= AF_LEVEL
overrun  output  1  sticky: a character was dropped because the FIFO was full

Behaviour:
- Reset (reset low, async):
  - wr_ptr = rd_ptr = 0, level = 0, overrun = 0.
  - Internal rx_done_q = 1, so a high rx_done at reset release does not push.
  - Outputs: rd_valid=0, empty=1, full=0, almost_full=0, rd_data/rd_ninth/rd_perr/rd_ferr=0.
  - Storage array is not reset.
- Edge detect: rx_done_q <= rx_done every clock. push_req = rx_done & ~rx_done_q. A held-high rx_done yields exactly one push.
- Push:
  - On the clock edge where push_req=1, the 11-bit word {rx_perr, rx_ferr, rx_ninth, rx_data} is sampled and written at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap of ADDR_W bits).
  - The entry is visible on rd_* with rd_valid=1 the cycle after the push (1-cycle write-to-read latency).
- Read (FWFT):
  - rd_valid = ~empty.
  - rd_* are combinational from the entry at rd_ptr, forced to 0 when empty.
  - Pop occurs when rd_valid & rd_ready at the clock edge; rd_ptr increments modulo DEPTH.
  - rd_ready while empty is ignored.
- Level update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - neither: unchanged.
- Full boundary:
  - push_req while full and no pop: character dropped, pointers and level unchanged, overrun <= 1.
  - push_req while full with pop in the same cycle: both occur, level stays DEPTH, no overrun.
- Empty boundary: push_req while empty with rd_ready=1: push only, since rd_valid was 0 that cycle. Data appears next cycle.
- flush:
  - When high: wr_ptr = rd_ptr = 0, level = 0 at that edge.
  - Overrides push and pop in the same cycle; the coincident character is discarded without setting overrun.
  - flush does not clear overrun.
- overrun:
  - Set by a dropped push, cleared by clr_overrun.
  - Set wins if both occur in the same cycle.
- Status: empty/full/almost_full derive combinationally from the registered level and are always consistent with it.
- Reset mid-operation: all contents are discarded immediately; no partial state survives.

Test Plan:
- Reset release with rx_done=1, then held high 5 cycles -> no push; level=0, rd_valid=0, empty=1.
- rx_data=0xA5, rx_ninth=1, rx_perr=0, rx_ferr=1, with a rx_done 0->1 pulse and rd_ready=0 -> next cycle: rd_valid=1, rd_data=0xA5, rd_ninth=1, rd_ferr=1, level=1. Then rd_ready=1 for 1 cycle -> empty=1, rd_data=0.
- Push 0x01..0x08 with DEPTH=8 -> almost_full=1 from level 6, full=1 at level 8. A 9th push 0x09 -> dropped, overrun=1, level=8. Drain -> data 0x01..0x08 in order.
- With full FIFO, assert push (0x55) and pop in the same cycle -> level stays 8, overrun=0, 0x55 read last. Then clr_overrun and a dropped push in the same cycle -> overrun remains 1.
- Wrap: push/pop 20 characters with interleaved timing -> output order matches input. With level=3, assert flush with a coincident push -> level=0, rd_valid=0, overrun unchanged.
- Assert reset mid-stream with level=5 -> level=0, all rd_* = 0 immediately (asynchronously).

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side character buffer placed after the UART receiver. A rising
// edge on rx_done captures one character {rx_perr, rx_ferr, rx_ninth,
// rx_data} into a first-word-fall-through FIFO. The host reads it through a
// valid/ready port and also sees occupancy, threshold and sticky overrun
// status.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   rx_data      received character (8 bits)
//   rx_ninth     received ninth bit
//   rx_perr      parity error of the current character
//   rx_ferr      framing error of the current character
//   rx_done      receiver completion level; only its rising edge captures
//   flush        synchronous clear of the FIFO contents (keeps overrun)
//   clr_overrun  clears the sticky overrun flag
//   rd_ready     host accepts the head entry
//   rd_valid     head entry available
//   rd_data      head data (0 when empty)
//   rd_ninth     head ninth bit (0 when empty)
//   rd_perr      head parity-error flag (0 when empty)
//   rd_ferr      head framing-error flag (0 when empty)
//   level        number of stored entries, 0..DEPTH
//   empty        level == 0
//   full         level == DEPTH
//   almost_full  level >= AF_LEVEL
//   overrun      sticky: a character was dropped because the FIFO was full
//
// Read handshake: the head entry transfers on a rising clock edge where
// rd_valid and rd_ready are both high. rd_valid does not depend on rd_ready,
// and rd_* hold steady until that transfer happens. rd_ready is ignored
// while rd_valid is low.

module uart_rx_fifo #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ninth,
  input  logic              rx_perr,
  input  logic              rx_ferr,
  input  logic              rx_done,
  input  logic              flush,
  input  logic              clr_overrun,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              rd_ninth,
  output logic              rd_perr,
  output logic              rd_ferr,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overrun
);

  localparam logic [ADDR_W:0]   LevelDepth = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LevelAf    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   LevelOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne     = ADDR_W'(1);

  // Storage word layout: {perr, ferr, ninth, data[7:0]}
  logic [10:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic              rxDoneQ;
  logic              pushReq;
  logic              popReq;
  logic              doPush;
  logic              doPop;
  logic              dropPush;
  logic [10:0]       wrWord;
  logic [10:0]       headWord;

  assign wrWord  = {rx_perr, rx_ferr, rx_ninth, rx_data};
  // rxDoneQ resets high so an rx_done already high at reset release does
  // not count as a new character.
  assign pushReq = rx_done & ~rxDoneQ;

  assign empty       = (level == '0);
  assign full        = (level == LevelDepth);
  assign almost_full = (level >= LevelAf);
  assign rd_valid    = ~empty;

  assign popReq = rd_valid & rd_ready;

  // When full, a push can still go ahead if the head leaves in the same
  // cycle. flush cancels both the push and the pop, and it also stops a
  // cancelled push from being counted as an overrun.
  assign doPush   = pushReq & ~flush & (~full | popReq);
  assign doPop    = popReq & ~flush;
  assign dropPush = pushReq & ~flush & full & ~popReq;

  assign headWord = empty ? 11'd0 : mem[rdPtr];
  assign rd_data  = headWord[7:0];
  assign rd_ninth = headWord[8];
  assign rd_ferr  = headWord[9];
  assign rd_perr  = headWord[10];

  // Storage has no reset; an empty FIFO masks stale contents on rd_*.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr] <= wrWord;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      overrun <= 1'b0;
      rxDoneQ <= 1'b1;
    end else begin
      rxDoneQ <= rx_done;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else begin
        if (doPush) begin
          wrPtr <= wrPtr + PtrOne;
        end
        if (doPop) begin
          rdPtr <= rdPtr + PtrOne;
        end
        case ({doPush, doPop})
          2'b10:   level <= level + LevelOne;
          2'b01:   level <= level - LevelOne;
          default: level <= level;
        endcase
      end
      // Setting wins over clearing when both happen in the same cycle.
      if (dropPush) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
